// File: rtl/dmem_port_arbiter.sv
// Two-port data memory arbiter: round-robin between the MEM stage (port 0) and the
// debug/loader master (port 1), with a bounded burst lock for port 1.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int MAX_LOCK      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [1:0]               size0,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic                     sext0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [1:0]               size1,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    input  logic                     sext1,
    input  logic                     lock1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [1:0]               m_size,
    output logic [ADDRESS_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0]    m_din,
    output logic                     m_sign_ext,
    output logic                     m_we,
    input  logic [DATA_WIDTH-1:0]    m_dout,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic                     rsp_err,
    output logic [DATA_WIDTH-1:0]    rsp_rdata
);

    localparam int LOCK_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    logic              ptr_reg, ptr_next;
    logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;

    logic [1:0]               we_vec, sext_vec, misalign_vec;
    logic [1:0]               size_arr  [2];
    logic [ADDRESS_WIDTH-1:0] addr_arr  [2];
    logic [DATA_WIDTH-1:0]    wdata_arr [2];

    logic grant0, grant1, any_grant, win_id, win_err;

    logic iss_valid_reg, iss_id_reg, iss_err_reg, iss_load_reg;

    assign we_vec       = {we1, we0};
    assign sext_vec     = {sext1, sext0};
    assign size_arr[0]  = size0;
    assign size_arr[1]  = size1;
    assign addr_arr[0]  = addr0;
    assign addr_arr[1]  = addr1;
    assign wdata_arr[0] = wdata0;
    assign wdata_arr[1] = wdata1;

    // size 2'b11 decodes as a word, so bit 1 alone selects the word alignment rule
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_align
            assign misalign_vec[gi] =
                ((size_arr[gi] == 2'b01) && addr_arr[gi][0]) ||
                (size_arr[gi][1] && (addr_arr[gi][1:0] != 2'b00));
        end
    endgenerate

    assign grant0    = req0 && (!req1 || !ptr_reg);
    assign grant1    = req1 && (!req0 || ptr_reg);
    assign any_grant = req0 || req1;
    assign win_id    = grant1;
    assign win_err   = misalign_vec[win_id];

    assign ack0 = rst_n && grant0;
    assign ack1 = rst_n && grant1;

    always_comb begin
        ptr_next      = ptr_reg;
        lock_cnt_next = lock_cnt_reg;
        if (grant0) begin
            ptr_next      = 1'b1;
            lock_cnt_next = '0;
        end else if (grant1) begin
            if (lock1 && (lock_cnt_reg < LOCK_W'(MAX_LOCK - 1))) begin
                ptr_next      = 1'b1;
                lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
            end else begin
                ptr_next      = 1'b0;
                lock_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= 1'b0;
            lock_cnt_reg <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // ISSUE stage: misaligned winners still occupy the slot but never write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_we          <= 1'b0;
            m_size        <= 2'b00;
            m_addr        <= '0;
            m_din         <= '0;
            m_sign_ext    <= 1'b0;
            iss_valid_reg <= 1'b0;
            iss_id_reg    <= 1'b0;
            iss_err_reg   <= 1'b0;
            iss_load_reg  <= 1'b0;
        end else if (any_grant) begin
            m_we          <= we_vec[win_id] && !win_err;
            m_size        <= size_arr[win_id];
            m_addr        <= addr_arr[win_id];
            m_din         <= wdata_arr[win_id];
            m_sign_ext    <= sext_vec[win_id];
            iss_valid_reg <= 1'b1;
            iss_id_reg    <= win_id;
            iss_err_reg   <= win_err;
            iss_load_reg  <= !we_vec[win_id];
        end else begin
            m_we          <= 1'b0;
            iss_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= iss_valid_reg;
            if (iss_valid_reg) begin
                rsp_id    <= iss_id_reg;
                rsp_err   <= iss_err_reg;
                rsp_rdata <= (iss_load_reg && !iss_err_reg) ? m_dout : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 16-byte write-first little-endian memory model.
module tb_dmem_port_arbiter;

    logic        clk, rst_n;
    logic        req0, we0, sext0, req1, we1, sext1, lock1;
    logic [1:0]  size0, size1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [1:0]  m_size;
    logic [3:0]  m_addr;
    logic [31:0] m_din, m_dout;
    logic        m_sign_ext, m_we;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .MAX_LOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0), .sext0(sext0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1), .sext1(sext1),
        .lock1(lock1), .ack0(ack0), .ack1(ack1),
        .m_size(m_size), .m_addr(m_addr), .m_din(m_din), .m_sign_ext(m_sign_ext),
        .m_we(m_we), .m_dout(m_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr] <= m_din[7:0];
            if (m_size != 2'b00) mem[m_addr + 4'd1] <= m_din[15:8];
            if (m_size[1]) begin
                mem[m_addr + 4'd2] <= m_din[23:16];
                mem[m_addr + 4'd3] <= m_din[31:24];
            end
        end
    end

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[m_addr];
        b1 = mem[m_addr + 4'd1];
        b2 = mem[m_addr + 4'd2];
        b3 = mem[m_addr + 4'd3];
        m_dout = {b3, b2, b1, b0};
        if (m_size == 2'b00)
            m_dout = m_sign_ext ? {{24{b0[7]}}, b0} : {24'h0, b0};
        else if (m_size == 2'b01)
            m_dout = m_sign_ext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid)
            $display("rsp id=%0d err=%0d rdata=%08h", rsp_id, rsp_err, rsp_rdata);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; size0 = 0; addr0 = 0; wdata0 = 0; sext0 = 0;
        req1 = 0; we1 = 0; size1 = 0; addr1 = 0; wdata1 = 0; sext1 = 0;
        lock1 = 0;
    endtask

    task automatic set_p0(input logic w, input logic [1:0] s, input logic [3:0] a,
                          input logic [31:0] d, input logic x);
        req0 = 1; we0 = w; size0 = s; addr0 = a; wdata0 = d; sext0 = x;
    endtask

    task automatic set_p1(input logic w, input logic [1:0] s, input logic [3:0] a,
                          input logic [31:0] d, input logic x);
        req1 = 1; we1 = w; size1 = s; addr1 = a; wdata1 = d; sext1 = x;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0 = 1; req1 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b%b want 00", ack0, ack1); end
        n_checks++; if (m_we !== 1'b0 || m_addr !== 4'h0 || m_din !== 32'h0 || m_size !== 2'b00 || m_sign_ext !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_port: we=%b addr=%h din=%h size=%b sx=%b want all 0", m_we, m_addr, m_din, m_size, m_sign_ext); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp: v=%b id=%b err=%b rd=%h want all 0", rsp_valid, rsp_id, rsp_err, rsp_rdata); end
        next_cycle();
        idle_inputs();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        next_cycle(); set_p0(1, 2'b10, 4'h4, 32'hDEADBEEF, 0);
        @(negedge clk);
        n_checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL sl_ack_c1: got %b%b want ack0=1 ack1=0", ack0, ack1); end
        next_cycle(); set_p0(0, 2'b10, 4'h4, 32'h0, 0);
        @(negedge clk);
        n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL sl_ack_c2: got %b want 1", ack0); end
        n_checks++; if (m_we !== 1'b1 || m_addr !== 4'h4 || m_din !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sl_issue_store: we=%b addr=%h din=%h want 1 4 deadbeef", m_we, m_addr, m_din); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sl_rsp_early: got %b want 0", rsp_valid); end
        next_cycle(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL sl_load_we: got %b want 0", m_we); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sl_rsp_store: v=%b id=%b err=%b rd=%h want 1 0 0 00000000", rsp_valid, rsp_id, rsp_err, rsp_rdata); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sl_rsp_load: v=%b id=%b rd=%h want 1 0 deadbeef", rsp_valid, rsp_id, rsp_rdata); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || m_we !== 1'b0) begin n_fail++; $display("FAIL sl_idle: v=%b we=%b want 0 0", rsp_valid, m_we); end
    endtask

    task automatic test_misalign();
        logic        exp_we  [8];
        logic        exp_v   [8];
        logic        exp_err [8];
        logic [31:0] exp_rd  [8];
        exp_we  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'h0};
        for (int i = 0; i < 8; i++) begin
            next_cycle(); idle_inputs();
            case (i)
                0: set_p1(1, 2'b10, 4'h0, 32'h11223344, 0);
                1: set_p1(0, 2'b01, 4'h3, 32'h0, 0);
                2: set_p1(1, 2'b01, 4'h1, 32'h0000BEEF, 0);
                3: set_p1(0, 2'b11, 4'h2, 32'h0, 0);
                4: set_p1(0, 2'b10, 4'h0, 32'h0, 0);
                default: ;
            endcase
            @(negedge clk);
            if (i < 5) begin
                n_checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin n_fail++; $display("FAIL mis_ack c%0d: got ack1=%b ack0=%b want 1 0", i, ack1, ack0); end
            end
            n_checks++; if (m_we !== exp_we[i]) begin n_fail++; $display("FAIL mis_we c%0d: got %b want %b", i, m_we, exp_we[i]); end
            n_checks++; if (rsp_valid !== exp_v[i]) begin n_fail++; $display("FAIL mis_rsp_valid c%0d: got %b want %b", i, rsp_valid, exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++; if (rsp_id !== 1'b1 || rsp_err !== exp_err[i] || rsp_rdata !== exp_rd[i]) begin
                    n_fail++; $display("FAIL mis_rsp c%0d: id=%b err=%b rd=%h want 1 %b %h", i, rsp_id, rsp_err, rsp_rdata, exp_err[i], exp_rd[i]); end
            end
        end
    endtask

    task automatic test_alternate();
        // ptr is 0 here (last grant went to port 1 without lock)
        for (int i = 0; i < 9; i++) begin
            next_cycle(); idle_inputs();
            if (i < 6) begin
                set_p0(0, 2'b10, 4'h4, 32'h0, 0);
                set_p1(0, 2'b10, 4'h0, 32'h0, 0);
            end
            @(negedge clk);
            if (i < 6) begin
                n_checks++; if (ack1 !== 1'(i % 2) || ack0 !== 1'((i + 1) % 2)) begin
                    n_fail++; $display("FAIL alt_ack c%0d: got ack0=%b ack1=%b want port %0d", i, ack0, ack1, i % 2); end
            end
            if (i >= 2 && i < 8) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) ||
                                rsp_rdata !== ((i % 2) != 0 ? 32'h11223344 : 32'hDEADBEEF)) begin
                    n_fail++; $display("FAIL alt_rsp c%0d: v=%b id=%b rd=%h want id %0d", i, rsp_valid, rsp_id, rsp_rdata, i % 2); end
            end
            if (i == 8) begin
                n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL alt_drain: got %b want 0", rsp_valid); end
            end
        end
    endtask

    task automatic test_lock();
        // ptr starts at 0: port 0, then 8 locked port-1 grants, repeated twice
        for (int i = 0; i < 21; i++) begin
            next_cycle(); idle_inputs();
            if (i < 19) begin
                set_p0(0, 2'b10, 4'h4, 32'h0, 0);
                set_p1(0, 2'b10, 4'h0, 32'h0, 0);
                lock1 = 1;
            end
            @(negedge clk);
            if (i < 19) begin
                n_checks++; if (ack1 !== ((i % 9) != 0) || ack0 !== ((i % 9) == 0)) begin
                    n_fail++; $display("FAIL lock_ack c%0d: got ack0=%b ack1=%b want port %0d", i, ack0, ack1, ((i % 9) != 0) ? 1 : 0); end
            end
            if (i >= 2) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== (((i - 2) % 9) != 0)) begin
                    n_fail++; $display("FAIL lock_rsp c%0d: v=%b id=%b want 1 %0d", i, rsp_valid, rsp_id, (((i - 2) % 9) != 0) ? 1 : 0); end
            end
        end
    endtask

    task automatic test_sext();
        logic [31:0] exp_rd [5];
        exp_rd = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'hFFFFFF00, 32'h00000080};
        for (int i = 0; i < 7; i++) begin
            next_cycle(); idle_inputs();
            case (i)
                0: set_p0(1, 2'b10, 4'h8, 32'h0080FF00, 0);
                1: set_p0(0, 2'b00, 4'hA, 32'h0, 1);
                2: set_p0(0, 2'b00, 4'hA, 32'h0, 0);
                3: set_p0(0, 2'b01, 4'h8, 32'h0, 1);
                4: set_p0(0, 2'b01, 4'hA, 32'h0, 1);
                default: ;
            endcase
            @(negedge clk);
            if (i == 2) begin
                n_checks++; if (m_sign_ext !== 1'b1 || m_size !== 2'b00 || m_addr !== 4'hA) begin
                    n_fail++; $display("FAIL sx_issue: sx=%b size=%b addr=%h want 1 00 a", m_sign_ext, m_size, m_addr); end
            end
            if (i >= 2) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp_rd[i - 2]) begin
                    n_fail++; $display("FAIL sx_rsp c%0d: v=%b err=%b rd=%h want 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exp_rd[i - 2]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        next_cycle(); idle_inputs(); set_p0(1, 2'b10, 4'hC, 32'h55667788, 0);
        repeat (3) begin next_cycle(); idle_inputs(); end
        set_p0(1, 2'b10, 4'hC, 32'h99999999, 0);
        @(negedge clk);
        n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL rmid_ack: got %b want 1", ack0); end
        next_cycle(); idle_inputs();
        req0 = 1;
        rst_n = 0;
        @(negedge clk);
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %b want 0", m_we); end
        n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_forced: got %b want 0", ack0); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_in_reset: got %b want 0", rsp_valid); end
        next_cycle(); idle_inputs(); rst_n = 1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_after: got %b want 0", rsp_valid); end
        next_cycle(); set_p0(0, 2'b10, 4'hC, 32'h0, 0);
        next_cycle(); idle_inputs();
        next_cycle();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55667788) begin
            n_fail++; $display("FAIL rmid_reload: v=%b rd=%h want 1 55667788", rsp_valid, rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misalign();
        test_alternate();
        test_lock();
        test_sext();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
